key_debounce4: RTL

//   Front end for the 4-to-2 priority encoder. Takes four raw, bouncing, asynchronous

---
 rtl/key_debounce4_pkg.sv | 21 ++
 rtl/key_debounce4_if.sv | 25 ++
 rtl/key_debounce4_debounce_bit.sv | 77 +++++++
 rtl/key_debounce4.sv | 77 +++++++
 4 files changed

// File: rtl/key_debounce4_pkg.sv
// ---------------------------------------------------------------------------
// key_debounce4_pkg
//   Shared definitions for the 4-key debounce front end: key count, the
//   two FSM state codes and the vector type that travels to the encoder.
//   No ports.
// ---------------------------------------------------------------------------
package key_debounce4_pkg;

  localparam int KEY_N = 4;

  localparam logic [0:0] KD_IDLE   = 1'b0;
  localparam logic [0:0] KD_ACTIVE = 1'b1;

  typedef logic [KEY_N-1:0] key_vec_t;

  // True when at least one key in the vector is asserted.
  function automatic logic any_key(input key_vec_t v);
    return |v;
  endfunction

endpackage

// File: rtl/key_debounce4_if.sv
// ---------------------------------------------------------------------------
// key_debounce4_if
//   Bundles the raw key levels and the debounced request outputs that feed
//   the downstream 4-to-2 priority encoder.
//   Signals:
//     key_in   raw, asynchronous, bouncing key levels (active-high)
//     in_code  debounced key vector (encoder in_code)
//     en       high while any debounced key is high (encoder en)
//     code_chg one-cycle strobe, first cycle in_code holds a new value
//   Modports:
//     master  drives key_in, observes the debounced outputs
//     slave   the debouncer itself
// ---------------------------------------------------------------------------
interface key_debounce4_if;
  import key_debounce4_pkg::*;

  key_vec_t key_in;
  key_vec_t in_code;
  logic     en;
  logic     code_chg;

  modport master (output key_in, input in_code, input en, input code_chg);
  modport slave  (input key_in, output in_code, output en, output code_chg);

endinterface

// File: rtl/key_debounce4_debounce_bit.sv
// ---------------------------------------------------------------------------
// debounce_bit
//   One key: 2-flop synchroniser followed by a persistence filter. A new
//   level is accepted only after the synchronised input has differed from
//   the accepted level for DEBOUNCE_CYCLES consecutive cycles.
//   Ports:
//     clk     clock, all state on rising edge
//     rst     asynchronous, active-high reset
//     din_i   raw asynchronous key level
//     dout_o  accepted (stable) level, registered
//     upd_o   high in the cycle before dout_o flips; the flip happens on the
//             next rising edge. Derived from registers only.
// ---------------------------------------------------------------------------
module debounce_bit #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic din_i,
  output logic dout_o,
  output logic upd_o
);

  // The counter runs down from DEBOUNCE_CYCLES-1; reaching zero while the
  // input still disagrees means the new level has persisted for the full
  // window.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1_q;
  logic             s2_q;
  logic             stable_q;
  logic             stable_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             upd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= din_i;
      s2_q <= s1_q;
    end
  end

  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    upd      = 1'b0;
    if (s2_q == stable_q) begin
      // Any return to the accepted level discards the partial count.
      cnt_d = CNT_LOAD;
    end else if (cnt_q == '0) begin
      stable_d = s2_q;
      cnt_d    = CNT_LOAD;
      upd      = 1'b1;
    end else begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable_q <= 1'b0;
      cnt_q    <= CNT_LOAD;
    end else begin
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign dout_o = stable_q;
  assign upd_o  = upd;

endmodule

// File: rtl/key_debounce4.sv
// ---------------------------------------------------------------------------
// key_debounce4
//   Front end for the 4-to-2 priority encoder. Synchronises and debounces
//   four raw key levels, presents the stable vector with an enable, and
//   pulses code_chg for one cycle whenever the vector changes.
//   Ports:
//     clk  clock, all state on rising edge
//     rst  asynchronous, active-high reset
//     kd   key_debounce4_if.slave: key_in in, in_code/en/code_chg out
//
//   FSM
//     state     | meaning
//     ----------+-----------------------------------------------
//     KD_IDLE   | no debounced key high, en = 0
//     KD_ACTIVE | at least one debounced key high, en = 1
// ---------------------------------------------------------------------------
module key_debounce4
  import key_debounce4_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 20
) (
  input  logic             clk,
  input  logic             rst,
  key_debounce4_if.slave   kd
);

  key_vec_t   stable_vec;
  key_vec_t   upd_vec;
  key_vec_t   next_code;
  logic [0:0] state_q;
  logic [0:0] state_d;
  logic       code_chg_q;

  for (genvar g = 0; g < KEY_N; g++) begin : g_bit
    debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_bit (
      .clk    (clk),
      .rst    (rst),
      .din_i  (kd.key_in[g]),
      .dout_o (stable_vec[g]),
      .upd_o  (upd_vec[g])
    );
  end

  // An update always flips the accepted level, so the vector seen after the
  // next edge is the current one with the updating bits inverted. Driving
  // the FSM from it keeps en in step with in_code.
  assign next_code = stable_vec ^ upd_vec;

  always_comb begin
    state_d = state_q;
    case (state_q)
      KD_IDLE:   if (any_key(next_code))  state_d = KD_ACTIVE;
      KD_ACTIVE: if (!any_key(next_code)) state_d = KD_IDLE;
      default:   state_d = KD_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= KD_IDLE;
      code_chg_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      // Bits finishing on the same edge merge into a single strobe.
      code_chg_q <= |upd_vec;
    end
  end

  assign kd.in_code  = stable_vec;
  assign kd.en       = (state_q == KD_ACTIVE);
  assign kd.code_chg = code_chg_q;

endmodule
